switch_debounce: RTL and testbench

Input conditioning stage between the 24 board DIP switches and the CPU's switch I/O port. It synchronises the raw switch levels into the CPU clock domain and debounces each bit independently, using a shared sampling tick. It presents a clean 24-bit level that the switch port samples directly. It also keeps a sticky per-bit change mask so software can tell which switches moved since the mask was last cleared.

---
 rtl/switch_debounce.sv | 105 ++++++++++
 tb/tb_switch_debounce.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce.sv
// Switch input conditioning: two-flop synchroniser, shared sample tick and
// per-bit tick-sampled debounce, with a sticky change mask for software.

module switch_debounce_bit #(
    parameter int STABLE_CNT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic level,
    output logic state,
    output logic accept
);
    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

    logic [CW-1:0] cnt;

    // Accepted on the tick that completes a run of differing samples.
    assign accept = tick && (level != state) && (cnt == CNT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            state <= 1'b0;
        end else if (tick) begin
            if (level == state) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                state <= level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module switch_debounce #(
    parameter int WIDTH      = 24,
    parameter int TICK_DIV   = 23000,
    parameter int STABLE_CNT = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] switch_raw,
    input  logic             clear_changes,
    output logic [WIDTH-1:0] switch_out,
    output logic [WIDTH-1:0] changed_mask,
    output logic             change_pulse,
    output logic             sample_tick
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PCNT_LAST = PW'(TICK_DIV - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] set_bits;
    logic [PW-1:0]    pcnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= switch_raw;
            sync2 <= sync1;
        end
    end

    // Tick is registered so it is high the cycle after the wrap point.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pcnt        <= '0;
            sample_tick <= 1'b0;
        end else begin
            sample_tick <= (pcnt == PCNT_LAST);
            pcnt        <= (pcnt == PCNT_LAST) ? '0 : pcnt + 1'b1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        switch_debounce_bit #(
            .STABLE_CNT(STABLE_CNT)
        ) u_bit (
            .clock  (clock),
            .reset  (reset),
            .tick   (sample_tick),
            .level  (sync2[i]),
            .state  (switch_out[i]),
            .accept (set_bits[i])
        );
    end

    // Newly set bits win over a simultaneous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            changed_mask <= '0;
            change_pulse <= 1'b0;
        end else begin
            changed_mask <= (changed_mask & ~{WIDTH{clear_changes}}) | set_bits;
            change_pulse <= |set_bits;
        end
    end
endmodule

// File: tb/tb_switch_debounce.sv
// Randomised and directed bench for switch_debounce with a sample-history
// reference model (TICK_DIV=4, STABLE_CNT=3).
module tb_switch_debounce;
    localparam int W  = 24;
    localparam int TD = 4;
    localparam int SC = 3;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] switch_raw = '0;
    logic         clear_changes = 1'b0;
    logic [W-1:0] switch_out;
    logic [W-1:0] changed_mask;
    logic         change_pulse;
    logic         sample_tick;

    int checks = 0;
    int fails  = 0;

    always #5 clock = ~clock;

    switch_debounce #(.WIDTH(W), .TICK_DIV(TD), .STABLE_CNT(SC)) u_dut (
        .clock         (clock),
        .reset         (reset),
        .switch_raw    (switch_raw),
        .clear_changes (clear_changes),
        .switch_out    (switch_out),
        .changed_mask  (changed_mask),
        .change_pulse  (change_pulse),
        .sample_tick   (sample_tick)
    );

    // Reference: a level is accepted when the last SC tick samples since
    // reset all differ from the current output.
    logic [W-1:0] m_sync1 = '0, m_sync2 = '0, m_out = '0, m_mask = '0, m_set;
    logic         m_pulse = 1'b0, m_tick = 1'b0;
    int           m_cyc = 0;
    logic [W-1:0] m_hist[$];

    initial forever begin
        @(posedge clock or posedge reset);
        if (reset) begin
            m_sync1 = '0; m_sync2 = '0; m_out = '0; m_mask = '0;
            m_pulse = 1'b0; m_tick = 1'b0; m_cyc = 0;
            m_hist.delete();
        end else begin
            m_set = '0;
            if (m_tick) begin
                m_hist.push_back(m_sync2);
                if (m_hist.size() > SC) void'(m_hist.pop_front());
                if (m_hist.size() == SC) begin
                    m_set = '1;
                    foreach (m_hist[j]) m_set &= m_hist[j] ^ m_out;
                end
            end
            m_out   = m_out ^ m_set;
            m_pulse = |m_set;
            m_mask  = (clear_changes ? '0 : m_mask) | m_set;
            m_tick  = (m_cyc % TD) == TD - 1;
            m_cyc++;
            m_sync2 = m_sync1;
            m_sync1 = switch_raw;
        end
    end

    task automatic do_reset(input logic [W-1:0] raw, input int settle);
        reset = 1'b1; switch_raw = raw; clear_changes = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (settle) @(negedge clock);
    endtask

    task automatic test_reset();
        int tick_k[$];
        int out_k  = -1;
        int pulses = 0;
        reset = 1'b1; switch_raw = '1; clear_changes = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({switch_out, changed_mask, change_pulse, sample_tick} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: out=%h mask=%h pulse=%b tick=%b, want all 0",
                     switch_out, changed_mask, change_pulse, sample_tick);
        end
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            checks++;
            if ({switch_out, changed_mask, change_pulse, sample_tick} !== {m_out, m_mask, m_pulse, m_tick}) begin
                fails++;
                $display("FAIL reset_model k=%0d: out=%h mask=%h pulse=%b tick=%b want %h %h %b %b",
                         k, switch_out, changed_mask, change_pulse, sample_tick, m_out, m_mask, m_pulse, m_tick);
            end
            if (sample_tick) tick_k.push_back(k);
            if (change_pulse) pulses++;
            if (out_k < 0 && switch_out === '1) out_k = k;
        end
        // The first tick is visible after edge TD-1 and is consumed by edge TD.
        checks++;
        if (tick_k.size() == 0 || tick_k[0] != TD - 1) begin
            fails++;
            $display("FAIL first_tick: at %0d, want %0d", tick_k.size() ? tick_k[0] : -1, TD - 1);
        end
        for (int i = 1; i < tick_k.size(); i++) begin
            checks++;
            if (tick_k[i] - tick_k[i-1] != TD) begin
                fails++;
                $display("FAIL tick_period: gap %0d, want %0d", tick_k[i] - tick_k[i-1], TD);
            end
        end
        checks++;
        if (out_k != TD * SC) begin
            fails++;
            $display("FAIL powerup_latency: switch_out all-ones at %0d, want %0d", out_k, TD * SC);
        end
        checks++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL powerup_pulse: %0d pulses, want 1", pulses);
        end
        checks++;
        if (changed_mask !== 24'hFFFFFF || switch_out !== 24'hFFFFFF) begin
            fails++;
            $display("FAIL powerup_state: out=%h mask=%h, want ffffff ffffff", switch_out, changed_mask);
        end
    endtask

    task automatic test_glitch();
        int pulses = 0;
        do_reset('0, 20);
        for (int k = 0; k < 28; k++) begin
            switch_raw[5] = (k < 2 * TD);
            @(negedge clock);
            checks++;
            if ({switch_out, changed_mask, change_pulse} !== {m_out, m_mask, m_pulse}) begin
                fails++;
                $display("FAIL glitch_model k=%0d: out=%h mask=%h pulse=%b want %h %h %b",
                         k, switch_out, changed_mask, change_pulse, m_out, m_mask, m_pulse);
            end
            if (change_pulse) pulses++;
        end
        checks++;
        if (switch_out !== '0 || pulses != 0 || changed_mask[5] !== 1'b0) begin
            fails++;
            $display("FAIL glitch: out=%h pulses=%0d mask5=%b, want 0 0 0", switch_out, pulses, changed_mask[5]);
        end
    endtask

    task automatic test_multibit();
        int pulses = 0;
        do_reset('0, 20);
        switch_raw = 24'hA5005A;
        for (int k = 0; k < 24; k++) begin
            @(negedge clock);
            checks++;
            if ({switch_out, changed_mask, change_pulse} !== {m_out, m_mask, m_pulse}) begin
                fails++;
                $display("FAIL multibit_model k=%0d: out=%h mask=%h pulse=%b want %h %h %b",
                         k, switch_out, changed_mask, change_pulse, m_out, m_mask, m_pulse);
            end
            if (change_pulse) pulses++;
        end
        checks++;
        if (switch_out !== 24'hA5005A || changed_mask !== 24'hA5005A || pulses != 1) begin
            fails++;
            $display("FAIL multibit: out=%h mask=%h pulses=%0d, want a5005a a5005a 1",
                     switch_out, changed_mask, pulses);
        end
    endtask

    task automatic test_collision();
        int n = 0;
        do_reset('0, 4);
        switch_raw = 24'h0000F0;
        repeat (20) @(negedge clock);
        checks++;
        if (changed_mask !== 24'h0000F0) begin
            fails++;
            $display("FAIL collision_setup: mask=%h, want 0000f0", changed_mask);
        end
        switch_raw = 24'h0000F1;
        // sync2 carries the new level from the second edge on.
        for (int k = 1; k < 30 && n < SC; k++) begin
            @(negedge clock);
            if (sample_tick && k >= 2) n++;
        end
        clear_changes = 1'b1;
        @(negedge clock);
        clear_changes = 1'b0;
        checks++;
        if (changed_mask !== 24'h000001 || switch_out !== 24'h0000F1 || change_pulse !== 1'b1) begin
            fails++;
            $display("FAIL collision: mask=%h out=%h pulse=%b, want 000001 0000f1 1",
                     changed_mask, switch_out, change_pulse);
        end
        checks++;
        if (changed_mask !== m_mask) begin
            fails++;
            $display("FAIL collision_model: mask=%h want %h", changed_mask, m_mask);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int rise_k = -1;
        do_reset('0, 4);
        switch_raw = 24'h000008;
        for (int k = 1; k < 30 && n < 2; k++) begin
            @(negedge clock);
            if (sample_tick && k >= 2) n++;
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({switch_out, changed_mask, change_pulse, sample_tick} !== '0) begin
            fails++;
            $display("FAIL midreset_outputs: out=%h mask=%h pulse=%b tick=%b, want all 0",
                     switch_out, changed_mask, change_pulse, sample_tick);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            checks++;
            if ({switch_out, changed_mask, change_pulse} !== {m_out, m_mask, m_pulse}) begin
                fails++;
                $display("FAIL midreset_model k=%0d: out=%h mask=%h pulse=%b want %h %h %b",
                         k, switch_out, changed_mask, change_pulse, m_out, m_mask, m_pulse);
            end
            if (rise_k < 0 && switch_out[3]) rise_k = k;
        end
        checks++;
        if (rise_k != TD * SC) begin
            fails++;
            $display("FAIL midreset_latency: bit3 rose at %0d, want %0d", rise_k, TD * SC);
        end
    endtask

    task automatic test_partial();
        int n = 0;
        int third_k = -1;
        int rise_k  = -1;
        do_reset('0, 4);
        for (int k = 0; k < 3 * TD; k++) begin
            switch_raw[7] = (k < 2 * TD);
            @(negedge clock);
            checks++;
            if (switch_out[7] !== 1'b0) begin
                fails++;
                $display("FAIL partial_early k=%0d: out7=%b, want 0", k, switch_out[7]);
            end
        end
        switch_raw[7] = 1'b1;
        for (int k = 1; k < 24; k++) begin
            @(negedge clock);
            checks++;
            if ({switch_out, changed_mask} !== {m_out, m_mask}) begin
                fails++;
                $display("FAIL partial_model k=%0d: out=%h mask=%h want %h %h",
                         k, switch_out, changed_mask, m_out, m_mask);
            end
            if (rise_k < 0 && switch_out[7]) rise_k = k;
            if (sample_tick && k >= 2) begin
                n++;
                if (n == SC) third_k = k;
            end
        end
        checks++;
        if (third_k < 0 || rise_k != third_k + 1) begin
            fails++;
            $display("FAIL partial_latency: bit7 rose at %0d, third tick at %0d", rise_k, third_k);
        end
    endtask

    task automatic test_random();
        int hold = 0;
        do_reset(W'($urandom), 0);
        for (int k = 0; k < 800; k++) begin
            if (hold == 0) begin
                switch_raw = switch_raw ^ (W'($urandom) & W'($urandom) & W'($urandom));
                hold = $urandom_range(1, 20);
            end
            hold--;
            clear_changes = ($urandom_range(0, 15) == 0);
            @(negedge clock);
            checks++;
            if ({switch_out, changed_mask, change_pulse, sample_tick} !== {m_out, m_mask, m_pulse, m_tick}) begin
                fails++;
                $display("FAIL random_model k=%0d: out=%h mask=%h pulse=%b tick=%b want %h %h %b %b",
                         k, switch_out, changed_mask, change_pulse, sample_tick, m_out, m_mask, m_pulse, m_tick);
            end
        end
        clear_changes = 1'b0;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_multibit();
        test_collision();
        test_reset_mid();
        test_partial();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
